// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of out-of-order completions, returning the
// overwritten physical registers of each retired instruction to the free list.
module reorder_buffer #(
  parameter int unsigned PRN_BITS     = 6,
  parameter int unsigned MAX_OPERANDS = 3,
  parameter int unsigned ROB_BITS     = 5
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   dispatch_valid,
  input  logic [MAX_OPERANDS-1:0]                dispatch_old_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  dispatch_old_prn,
  output logic                                   dispatch_ready,
  output logic [ROB_BITS-1:0]                    dispatch_tag,
  input  logic [MAX_OPERANDS-1:0]                complete_valid,
  input  logic [MAX_OPERANDS-1:0][ROB_BITS-1:0]  complete_tag,
  output logic [MAX_OPERANDS-1:0]                free_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  free_prns,
  output logic                                   retire_valid,
  output logic [ROB_BITS-1:0]                    retire_tag,
  output logic [ROB_BITS:0]                      count
);

  localparam int unsigned DEPTH = 1 << ROB_BITS;
  localparam logic [ROB_BITS:0] FULL_COUNT = (ROB_BITS+1)'(DEPTH);

  logic [DEPTH-1:0]                          valid_q, valid_d;
  logic [DEPTH-1:0]                          done_q, done_d;
  logic [MAX_OPERANDS-1:0]                   old_valid_q [DEPTH];
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]     old_prn_q   [DEPTH];
  logic [ROB_BITS-1:0]                       head_q, head_d;
  logic [ROB_BITS-1:0]                       tail_q, tail_d;
  logic [ROB_BITS:0]                         count_q, count_d;
  logic [MAX_OPERANDS-1:0]                   free_valid_q;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]     free_prns_q;
  logic                                      retire_valid_q;
  logic [ROB_BITS-1:0]                       retire_tag_q;
  logic                                      dispatch_en;
  logic                                      retire_en;

  // Space is judged from registered occupancy only; a same-cycle retire never frees a slot.
  assign dispatch_ready = (count_q < FULL_COUNT);
  assign dispatch_tag   = tail_q;
  assign dispatch_en    = dispatch_valid && dispatch_ready;
  assign retire_en      = valid_q[head_q] && done_q[head_q];

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Completion first, then retire clear, then dispatch write: later steps win on overlap.
    for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
      if (complete_valid[i] && valid_q[complete_tag[i]]) begin
        done_d[complete_tag[i]] = 1'b1;
      end
    end
    if (retire_en) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + ROB_BITS'(1);
    end
    if (dispatch_en) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      tail_d          = tail_q + ROB_BITS'(1);
    end
    unique case ({dispatch_en, retire_en})
      2'b10:   count_d = count_q + (ROB_BITS+1)'(1);
      2'b01:   count_d = count_q - (ROB_BITS+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      free_valid_q   <= '0;
      free_prns_q    <= '0;
      retire_valid_q <= 1'b0;
      retire_tag_q   <= '0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      free_valid_q   <= retire_en ? old_valid_q[head_q] : '0;
      free_prns_q    <= old_prn_q[head_q];
      retire_valid_q <= retire_en;
      retire_tag_q   <= head_q;
    end
  end

  // Payload needs no reset: it is only read behind a valid entry.
  always_ff @(posedge clk) begin
    if (dispatch_en && !rst) begin
      old_valid_q[tail_q] <= dispatch_old_valid;
      old_prn_q[tail_q]   <= dispatch_old_prn;
    end
  end

  assign free_valid   = free_valid_q;
  assign free_prns    = free_prns_q;
  assign retire_valid = retire_valid_q;
  assign retire_tag   = retire_tag_q;
  assign count        = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios then random traffic, every cycle
// compared against a queue-based model of in-order commit.
module tb_reorder_buffer;

  localparam int unsigned PB = 6;
  localparam int unsigned NO = 3;
  localparam int unsigned RB = 5;
  localparam int unsigned DEPTH = 1 << RB;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   dispatch_valid = 1'b0;
  logic [NO-1:0]          dispatch_old_valid = '0;
  logic [NO-1:0][PB-1:0]  dispatch_old_prn = '0;
  logic                   dispatch_ready;
  logic [RB-1:0]          dispatch_tag;
  logic [NO-1:0]          complete_valid = '0;
  logic [NO-1:0][RB-1:0]  complete_tag = '0;
  logic [NO-1:0]          free_valid;
  logic [NO-1:0][PB-1:0]  free_prns;
  logic                   retire_valid;
  logic [RB-1:0]          retire_tag;
  logic [RB:0]            count;

  reorder_buffer #(.PRN_BITS(PB), .MAX_OPERANDS(NO), .ROB_BITS(RB)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_old_valid(dispatch_old_valid),
    .dispatch_old_prn(dispatch_old_prn), .dispatch_ready(dispatch_ready),
    .dispatch_tag(dispatch_tag), .complete_valid(complete_valid),
    .complete_tag(complete_tag), .free_valid(free_valid), .free_prns(free_prns),
    .retire_valid(retire_valid), .retire_tag(retire_tag), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RB-1:0]         tag;
    logic [NO-1:0]         ov;
    logic [NO-1:0][PB-1:0] op;
    bit                    done;
  } ent_t;

  ent_t                  q[$];
  int unsigned           next_tag = 0;
  bit                    exp_rv = 0;
  logic [RB-1:0]         exp_rt = '0;
  logic [NO-1:0]         exp_fv = '0;
  logic [NO-1:0][PB-1:0] exp_fp = '0;
  int                    ntotal = 0;
  int                    npass = 0;
  int                    nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
  task automatic step(input bit r, input bit dv, input logic [NO-1:0] ov,
                      input logic [NO-1:0][PB-1:0] op, input logic [NO-1:0] cv,
                      input logic [NO-1:0][RB-1:0] ct);
    bit   ret, rdy;
    ent_t h, e;
    rst = r; dispatch_valid = dv; dispatch_old_valid = ov; dispatch_old_prn = op;
    complete_valid = cv; complete_tag = ct;
    @(posedge clk);
    if (r) begin
      q.delete(); next_tag = 0; exp_rv = 0; exp_fv = '0;
    end else begin
      ret = (q.size() > 0) && q[0].done;
      rdy = q.size() < DEPTH;
      if (ret) h = q[0];
      for (int i = 0; i < int'(NO); i++)
        if (cv[i])
          for (int k = 0; k < q.size(); k++)
            if (q[k].tag == ct[i]) q[k].done = 1;
      if (ret) begin
        void'(q.pop_front());
        exp_rv = 1; exp_rt = h.tag; exp_fv = h.ov; exp_fp = h.op;
      end else begin
        exp_rv = 0; exp_fv = '0;
      end
      if (dv && rdy) begin
        e.tag = RB'(next_tag % DEPTH); e.ov = ov; e.op = op; e.done = 0;
        q.push_back(e);
        next_tag++;
      end
    end
    #1;
    chk("count", 32'(count), 32'(q.size()));
    chk("dispatch_ready", 32'(dispatch_ready), 32'(q.size() < DEPTH));
    chk("dispatch_tag", 32'(dispatch_tag), 32'(next_tag % DEPTH));
    chk("retire_valid", 32'(retire_valid), 32'(exp_rv));
    chk("free_valid", 32'(free_valid), 32'(exp_fv));
    if (exp_rv) begin
      chk("retire_tag", 32'(retire_tag), 32'(exp_rt));
      for (int i = 0; i < int'(NO); i++)
        if (exp_fv[i]) chk("free_prns", 32'(free_prns[i]), 32'(exp_fp[i]));
    end
  endtask

  task automatic idle();
    step(0, 0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    step(1, 0, '0, '0, '0, '0);
  endtask

  task automatic disp(input logic [NO-1:0] ov, input logic [NO-1:0][PB-1:0] op);
    step(0, 1, ov, op, '0, '0);
  endtask

  task automatic comp(input logic [RB-1:0] t);
    logic [NO-1:0][RB-1:0] ct;
    ct = '0; ct[0] = t;
    step(0, 0, '0, '0, 3'b001, ct);
  endtask

  initial begin
    logic [NO-1:0][PB-1:0] op;
    logic [NO-1:0][RB-1:0] ct;
    logic [NO-1:0]         cv;

    // Reset and single instruction with one old mapping
    do_reset(); idle();
    op = '0; op[0] = 6'd17;
    chk("tag0_offered", 32'(dispatch_tag), 32'd0);
    disp(3'b001, op);
    comp(5'd0); idle(); idle(); idle();

    // Out-of-order completion, no-old-mapping retire on tag 1
    do_reset();
    op = '0; op[0] = 6'd3; disp(3'b001, op);
    disp(3'b000, '0);
    op = '0; op[1] = 6'd40; op[2] = 6'd41; disp(3'b110, op);
    comp(5'd2); idle(); comp(5'd1); idle();
    comp(5'd0); idle(); idle(); idle(); idle();

    // Fill to capacity, reject 33rd, then drain one and reuse tag 0
    do_reset();
    for (int i = 0; i < 33; i++) begin
      op = '0; op[0] = PB'(i); disp(3'b001, op);
    end
    chk("full_ready", 32'(dispatch_ready), 32'd0);
    comp(5'd0); idle(); idle();
    op = '0; op[0] = 6'd63; disp(3'b001, op);
    idle();

    // Steady dispatch+complete+retire across the 31->0 wrap, duplicate tags on lanes
    do_reset();
    disp(3'b001, '0);
    for (int i = 1; i < 40; i++) begin
      op = '0; op[0] = PB'(i); op[2] = PB'(i + 7);
      ct = '0; ct[0] = RB'(i - 1); ct[1] = RB'(i - 1);
      step(0, 1, 3'b101, op, 3'b011, ct);
    end
    idle(); idle(); idle();

    // Reset mid-operation with dispatch and completion also asserted on the reset edge
    do_reset();
    for (int i = 0; i < 5; i++) disp(3'b011, '0);
    comp(5'd1); comp(5'd2);
    ct = '0; ct[0] = 5'd0;
    step(1, 1, 3'b111, '0, 3'b001, ct);
    for (int i = 0; i < 4; i++) idle();

    // Spurious completion to an empty slot must not pre-mark it done
    do_reset();
    comp(5'd7);
    for (int i = 0; i < 8; i++) disp(3'b001, '0);
    for (int i = 0; i < 7; i++) comp(RB'(i));
    for (int i = 0; i < 9; i++) idle();
    comp(5'd7); idle(); idle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < int'(NO); i++) begin
        op[i] = PB'($urandom);
        if (q.size() > 0 && ($urandom % 4) != 0)
          ct[i] = q[$urandom % q.size()].tag;
        else
          ct[i] = RB'($urandom);
      end
      cv = NO'($urandom);
      step(($urandom % 250) == 0, ($urandom % 4) != 0, NO'($urandom), op, cv, ct);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
